demo_timer: RTL and testbench

Generates the free-running demo timeline that drives the demo sequencer. It turns a periodic tick, such as the frame or row-rate strobe, into the `timer` count, prescaled by `DIV`. It also supports pause, skip-to-next-section and restart controls, and handles end-of-demo by looping back or stopping. The block sits directly upstream of the sequencer and emits one-cycle strobes whenever the timeline moves.

---
 rtl/demo_timer.sv | 113 +++++++++++
 tb/tb_demo_timer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demo_timer.sv
// Demo timeline counter: prescales an incoming tick into a sectioned time value,
// with pause, skip-to-next-section, restart and loop/stop handling at the end.
module demo_timer #(
    parameter int TIME_BITS    = 13,
    parameter int SECTION_BITS = 10,
    parameter int DIV          = 2,
    parameter int LOOP         = 1,
    parameter int LOOP_SECTION = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 enable,
    input  logic                 skip,
    input  logic                 restart,
    output logic [TIME_BITS-1:0] timer,
    output logic                 step,
    output logic                 section_start,
    output logic                 done
);

    localparam int SW = TIME_BITS - SECTION_BITS;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]        PCNT_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0]        LAST_SEC  = {SW{1'b1}};
    localparam logic [TIME_BITS-1:0] TIME_ONES = {TIME_BITS{1'b1}};
    localparam logic [TIME_BITS-1:0] LOOP_TIME = TIME_BITS'(LOOP_SECTION) << SECTION_BITS;

    logic [TIME_BITS-1:0] timer_q, timer_d;
    logic [PW-1:0]        pcnt_q, pcnt_d;
    logic                 done_q, done_d;
    logic                 step_q, step_d;
    logic                 section_start_q, section_start_d;
    logic                 skip_q, restart_q;

    logic                 skip_e, restart_e;
    logic [SW-1:0]        section, section_nxt;
    logic                 write;

    assign skip_e      = skip & ~skip_q;
    assign restart_e   = restart & ~restart_q;
    assign section     = timer_q[TIME_BITS-1:SECTION_BITS];
    assign section_nxt = section + SW'(1);

    // Events are strictly prioritised; a lower-priority event in the same cycle is dropped.
    always_comb begin
        timer_d = timer_q;
        pcnt_d  = pcnt_q;
        done_d  = done_q;
        write   = 1'b0;
        if (restart_e) begin
            timer_d = '0;
            pcnt_d  = '0;
            done_d  = 1'b0;
            write   = 1'b1;
        end else if (skip_e && !done_q) begin
            pcnt_d = '0;
            write  = 1'b1;
            if (section != LAST_SEC) begin
                timer_d = {section_nxt, {SECTION_BITS{1'b0}}};
            end else if (LOOP != 0) begin
                timer_d = LOOP_TIME;
            end else begin
                timer_d = TIME_ONES;
                done_d  = 1'b1;
            end
        end else if (tick && enable && !done_q) begin
            if (pcnt_q != PCNT_LAST) begin
                pcnt_d = pcnt_q + PW'(1);
            end else begin
                pcnt_d = '0;
                if (timer_q != TIME_ONES) begin
                    timer_d = timer_q + TIME_BITS'(1);
                    write   = 1'b1;
                end else if (LOOP != 0) begin
                    timer_d = LOOP_TIME;
                    write   = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
        end
        step_d          = write;
        section_start_d = write && (timer_d[SECTION_BITS-1:0] == '0);
    end

    // Edge registers reset high so inputs held high across reset release do not fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q         <= '0;
            pcnt_q          <= '0;
            done_q          <= 1'b0;
            step_q          <= 1'b0;
            section_start_q <= 1'b0;
            skip_q          <= 1'b1;
            restart_q       <= 1'b1;
        end else begin
            timer_q         <= timer_d;
            pcnt_q          <= pcnt_d;
            done_q          <= done_d;
            step_q          <= step_d;
            section_start_q <= section_start_d;
            skip_q          <= skip;
            restart_q       <= restart;
        end
    end

    assign timer         = timer_q;
    assign step          = step_q;
    assign section_start = section_start_q;
    assign done          = done_q;

endmodule

// File: tb/tb_demo_timer.sv
// Directed bench for demo_timer: default, LOOP=0 and DIV=1 instances share one stimulus.
module tb_demo_timer;

    logic clk, rst_n, tick, enable, skip, restart;
    logic [12:0] timer_a, timer_s, timer_1;
    logic step_a, step_s, step_1;
    logic ss_a, ss_s, ss_1;
    logic done_a, done_s, done_1;

    int errors = 0;
    int checks = 0;

    demo_timer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .skip(skip), .restart(restart),
        .timer(timer_a), .step(step_a), .section_start(ss_a), .done(done_a)
    );

    demo_timer #(.LOOP(0)) dut_stop (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .skip(skip), .restart(restart),
        .timer(timer_s), .step(step_s), .section_start(ss_s), .done(done_s)
    );

    demo_timer #(.DIV(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .skip(skip), .restart(restart),
        .timer(timer_1), .step(step_1), .section_start(ss_1), .done(done_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; skip = 1'b0; restart = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic skip_edge();
        skip = 1'b1;
        cycle();
        skip = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (timer_a !== 13'd0) begin errors++; $display("FAIL reset_timer: got %0d exp 0", timer_a); end
        checks++; if (step_a !== 1'b0) begin errors++; $display("FAIL reset_step: got %b exp 0", step_a); end
        checks++; if (ss_a !== 1'b0) begin errors++; $display("FAIL reset_ss: got %b exp 0", ss_a); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done_s); end
    endtask

    task automatic test_prescale();
        tick_once();
        checks++; if (timer_a !== 13'd0 || step_a !== 1'b0) begin errors++; $display("FAIL prescale_t1: timer %0d step %b exp 0 0", timer_a, step_a); end
        cycle();
        tick_once();
        checks++; if (timer_a !== 13'd1 || step_a !== 1'b1) begin errors++; $display("FAIL prescale_t2: timer %0d step %b exp 1 1", timer_a, step_a); end
        cycle();
        checks++; if (timer_a !== 13'd1 || step_a !== 1'b0) begin errors++; $display("FAIL prescale_gap: timer %0d step %b exp 1 0", timer_a, step_a); end
        tick_once();
        checks++; if (timer_a !== 13'd1 || step_a !== 1'b0) begin errors++; $display("FAIL prescale_t3: timer %0d step %b exp 1 0", timer_a, step_a); end
        cycle();
        tick_once();
        checks++; if (timer_a !== 13'd2 || step_a !== 1'b1 || ss_a !== 1'b0) begin errors++; $display("FAIL prescale_t4: timer %0d step %b ss %b exp 2 1 0", timer_a, step_a, ss_a); end
        checks++; if (timer_1 !== 13'd4) begin errors++; $display("FAIL prescale_div1: got %0d exp 4", timer_1); end
    endtask

    task automatic test_skip();
        // 7 more ticks: timer 2 -> 5 with the prescaler left half-way
        for (int i = 0; i < 7; i++) tick_once();
        checks++; if (timer_a !== 13'd5) begin errors++; $display("FAIL skip_pre: got %0d exp 5", timer_a); end
        skip = 1'b1;
        cycle();
        checks++; if (timer_a !== 13'd1024 || step_a !== 1'b1 || ss_a !== 1'b1) begin errors++; $display("FAIL skip_jump: timer %0d step %b ss %b exp 1024 1 1", timer_a, step_a, ss_a); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (timer_a !== 13'd1024 || step_a !== 1'b0) begin errors++; $display("FAIL skip_hold: timer %0d step %b exp 1024 0", timer_a, step_a); end
        end
        skip = 1'b0;
        cycle();
        tick_once();
        checks++; if (timer_a !== 13'd1024) begin errors++; $display("FAIL skip_pcnt1: got %0d exp 1024", timer_a); end
        tick_once();
        checks++; if (timer_a !== 13'd1025 || step_a !== 1'b1 || ss_a !== 1'b0) begin errors++; $display("FAIL skip_pcnt2: timer %0d step %b ss %b exp 1025 1 0", timer_a, step_a, ss_a); end
    endtask

    task automatic test_loop_stop();
        do_reset();
        for (int i = 0; i < 7; i++) skip_edge();
        checks++; if (timer_a !== 13'd7168) begin errors++; $display("FAIL loop_7skips: got %0d exp 7168", timer_a); end
        checks++; if (timer_s !== 13'd7168) begin errors++; $display("FAIL stop_7skips: got %0d exp 7168", timer_s); end
        skip = 1'b1;
        cycle();
        checks++; if (timer_a !== 13'd1024 || ss_a !== 1'b1 || step_a !== 1'b1) begin errors++; $display("FAIL loop_wrap: timer %0d ss %b step %b exp 1024 1 1", timer_a, ss_a, step_a); end
        checks++; if (timer_s !== 13'd8191 || done_s !== 1'b1 || step_s !== 1'b1 || ss_s !== 1'b0) begin errors++; $display("FAIL stop_end: timer %0d done %b step %b ss %b exp 8191 1 1 0", timer_s, done_s, step_s, ss_s); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL loop_no_done: got %b exp 0", done_a); end
        skip = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            tick_once();
            checks++; if (timer_s !== 13'd8191 || step_s !== 1'b0 || done_s !== 1'b1) begin errors++; $display("FAIL stop_tick: timer %0d step %b done %b exp 8191 0 1", timer_s, step_s, done_s); end
        end
        skip = 1'b1;
        cycle();
        checks++; if (timer_s !== 13'd8191 || step_s !== 1'b0 || done_s !== 1'b1) begin errors++; $display("FAIL stop_skip: timer %0d step %b done %b exp 8191 0 1", timer_s, step_s, done_s); end
        skip = 1'b0;
        cycle();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        checks++; if (timer_s !== 13'd0 || done_s !== 1'b0 || step_s !== 1'b1 || ss_s !== 1'b1) begin errors++; $display("FAIL stop_restart: timer %0d done %b step %b ss %b exp 0 0 1 1", timer_s, done_s, step_s, ss_s); end
        cycle();
    endtask

    task automatic test_tick_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) skip_edge();
        tick = 1'b1;
        for (int i = 1; i <= 1023; i++) begin
            cycle();
            checks++; if (timer_1 !== 13'(7168 + i) || step_1 !== 1'b1) begin errors++; $display("FAIL div1_run: timer %0d step %b exp %0d 1", timer_1, step_1, 7168 + i); end
        end
        cycle();
        tick = 1'b0;
        checks++; if (timer_1 !== 13'd1024 || step_1 !== 1'b1 || ss_1 !== 1'b1) begin errors++; $display("FAIL div1_wrap: timer %0d step %b ss %b exp 1024 1 1", timer_1, step_1, ss_1); end
        cycle();
    endtask

    task automatic test_priority();
        do_reset();
        skip_edge();
        skip_edge();
        for (int i = 0; i < 10; i++) tick_once();
        checks++; if (timer_a !== 13'd2053 || done_a !== 1'b0) begin errors++; $display("FAIL prio_pre: timer %0d done %b exp 2053 0", timer_a, done_a); end
        restart = 1'b1; skip = 1'b1; tick = 1'b1;
        cycle();
        restart = 1'b0; skip = 1'b0; tick = 1'b0;
        checks++; if (timer_a !== 13'd0 || step_a !== 1'b1 || ss_a !== 1'b1) begin errors++; $display("FAIL prio_restart: timer %0d step %b ss %b exp 0 1 1", timer_a, step_a, ss_a); end
        tick_once();
        checks++; if (timer_a !== 13'd0 || step_a !== 1'b0) begin errors++; $display("FAIL prio_pcnt1: timer %0d step %b exp 0 0", timer_a, step_a); end
        tick_once();
        checks++; if (timer_a !== 13'd1) begin errors++; $display("FAIL prio_pcnt2: got %0d exp 1", timer_a); end
    endtask

    task automatic test_pause();
        do_reset();
        for (int i = 0; i < 3; i++) tick_once();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_once();
            checks++; if (timer_a !== 13'd1 || step_a !== 1'b0) begin errors++; $display("FAIL pause_tick: timer %0d step %b exp 1 0", timer_a, step_a); end
        end
        enable = 1'b1;
        tick_once();
        checks++; if (timer_a !== 13'd2 || step_a !== 1'b1) begin errors++; $display("FAIL pause_resume: timer %0d step %b exp 2 1", timer_a, step_a); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) tick_once();
        tick = 1'b1;
        @(posedge clk);
        #2;
        skip = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (timer_a !== 13'd0 || step_a !== 1'b0 || ss_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL async_reset: timer %0d step %b ss %b done %b exp 0 0 0 0", timer_a, step_a, ss_a, done_a); end
        tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (timer_a !== 13'd0 || step_a !== 1'b0) begin errors++; $display("FAIL reset_skip_held: timer %0d step %b exp 0 0", timer_a, step_a); end
        end
        skip = 1'b0;
        cycle();
        skip = 1'b1;
        cycle();
        skip = 1'b0;
        checks++; if (timer_a !== 13'd1024 || step_a !== 1'b1) begin errors++; $display("FAIL reset_skip_after: timer %0d step %b exp 1024 1", timer_a, step_a); end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_skip();
        test_loop_stop();
        test_tick_wrap();
        test_priority();
        test_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
